// File: rtl/pixel_frame_scheduler.sv
// pixel_frame_scheduler: sequences one image frame through erase, expose and convert
// phases, then reads the rows one at a time. Each captured row is handed off on a
// valid/ready handshake.
// Optional build macro PIXEL_CONTINUOUS_EN: DONE loops back to ERASE so that frames run
// back-to-back after the first start. Without it, DONE returns to IDLE and each start
// runs one frame.
module pixel_frame_scheduler #(
  parameter int unsigned H         = 4,
  parameter int unsigned W         = 4,
  parameter int unsigned C_ERASE   = 5,
  parameter int unsigned C_EXPOSE  = 255,
  parameter int unsigned C_CONVERT = 255,
  parameter int unsigned C_READ    = 5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 erase,
  output logic                                 expose,
  output logic                                 convert,
  output logic [H-1:0]                         read,
  input  logic [8*W-1:0]                       pix_data,
  output logic [8*W-1:0]                       row_data,
  output logic [((H > 1) ? $clog2(H) : 1)-1:0] row_idx,
  output logic                                 row_valid,
  input  logic                                 row_ready,
  output logic                                 busy,
  output logic                                 frame_done
);

  localparam int unsigned RowW = (H > 1) ? $clog2(H) : 1;

  localparam logic [15:0]     LastErase   = 16'(C_ERASE - 1);
  localparam logic [15:0]     LastExpose  = 16'(C_EXPOSE - 1);
  localparam logic [15:0]     LastConvert = 16'(C_CONVERT - 1);
  localparam logic [15:0]     LastRead    = 16'(C_READ - 1);
  localparam logic [RowW-1:0] LastRow     = RowW'(H - 1);

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StExpose,
    StConvert,
    StRead,
    StWaitAck,
    StDone
  } state_t;

  state_t          r_state;
  logic [15:0]     r_cnt;
  logic [RowW-1:0] r_row;
  logic [8*W-1:0]  r_row_data;
  logic [RowW-1:0] r_row_idx;
  logic            r_row_valid;

  state_t          w_state_next;
  logic [15:0]     w_cnt_next;
  logic [RowW-1:0] w_row_next;
  logic [8*W-1:0]  w_row_data_next;
  logic [RowW-1:0] w_row_idx_next;
  logic            w_row_valid_next;
  logic            w_transfer;

  assign w_transfer = r_row_valid && row_ready;

  // Next-state logic for the phase sequencer, row counter and output row register.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt + 16'd1;
    w_row_next       = r_row;
    w_row_data_next  = r_row_data;
    w_row_idx_next   = r_row_idx;
    w_row_valid_next = r_row_valid;

    unique case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        w_row_next = '0;
        if (start) begin
          w_state_next = StErase;
        end
      end
      StErase: begin
        if (r_cnt == LastErase) begin
          w_state_next = StExpose;
          w_cnt_next   = '0;
        end
      end
      StExpose: begin
        if (r_cnt == LastExpose) begin
          w_state_next = StConvert;
          w_cnt_next   = '0;
        end
      end
      StConvert: begin
        if (r_cnt == LastConvert) begin
          w_state_next = StRead;
          w_cnt_next   = '0;
          w_row_next   = '0;
        end
      end
      StRead: begin
        // The array drives the selected row on pix_data during the final read cycle.
        if (r_cnt == LastRead) begin
          w_state_next     = StWaitAck;
          w_cnt_next       = '0;
          w_row_data_next  = pix_data;
          w_row_idx_next   = r_row;
          w_row_valid_next = 1'b1;
        end
      end
      StWaitAck: begin
        w_cnt_next = '0;
        if (w_transfer) begin
          w_row_valid_next = 1'b0;
          if (r_row != LastRow) begin
            w_state_next = StRead;
            w_row_next   = r_row + RowW'(1);
          end else begin
            w_state_next = StDone;
          end
        end
      end
      StDone: begin
        w_cnt_next = '0;
        w_row_next = '0;
`ifdef PIXEL_CONTINUOUS_EN
        w_state_next = StErase;
`else
        w_state_next = StIdle;
`endif
      end
      default: begin
        w_state_next     = StIdle;
        w_cnt_next       = '0;
        w_row_next       = '0;
        w_row_valid_next = 1'b0;
      end
    endcase
  end

  // Phase-decoded outputs. The row select is one-hot on the current row, and only in READ.
  always_comb begin
    erase      = (r_state == StErase);
    expose     = (r_state == StExpose);
    convert    = (r_state == StConvert);
    busy       = (r_state != StIdle);
    frame_done = (r_state == StDone);
    read       = '0;
    for (int i = 0; i < H; i++) begin
      read[i] = (r_state == StRead) && (r_row == RowW'(i));
    end
  end

  assign row_data  = r_row_data;
  assign row_idx   = r_row_idx;
  assign row_valid = r_row_valid;

  // State and datapath registers. Reset wins over any pending row transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_row       <= '0;
      r_row_data  <= '0;
      r_row_idx   <= '0;
      r_row_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_row       <= w_row_next;
      r_row_data  <= w_row_data_next;
      r_row_idx   <= w_row_idx_next;
      r_row_valid <= w_row_valid_next;
    end
  end

endmodule

// File: tb/tb_pixel_frame_scheduler.sv
// Self-checking bench for pixel_frame_scheduler. A timeline model works out every output
// from the frame offset, counted in cycles since start with handshake stall cycles removed.
// Directed scenarios add hand-computed literal checks at fixed cycles.
module tb_pixel_frame_scheduler;

  localparam int H      = 4;
  localparam int W      = 4;
  localparam int CE     = 5;
  localparam int CX     = 10;
  localparam int CC     = 8;
  localparam int CR     = 2;
  localparam int RW     = (H > 1) ? $clog2(H) : 1;
  localparam int B      = CE + CX + CC;  // last convert cycle offset
  localparam int ROWLEN = CR + 1;        // read cycles plus one handshake cycle

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           row_ready = 1'b0;
  logic           erase, expose, convert, row_valid, busy, frame_done;
  logic [H-1:0]   read;
  logic [8*W-1:0] pix_data, row_data;
  logic [RW-1:0]  row_idx;
  logic           pix_const = 1'b0;
  bit             chk_en = 1'b0;
  int             n_cmp = 0;
  int             n_bad = 0;

  pixel_frame_scheduler #(
    .H(H), .W(W), .C_ERASE(CE), .C_EXPOSE(CX), .C_CONVERT(CC), .C_READ(CR)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .erase(erase), .expose(expose), .convert(convert), .read(read),
    .pix_data(pix_data), .row_data(row_data), .row_idx(row_idx),
    .row_valid(row_valid), .row_ready(row_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [8*W-1:0] row_pattern(input int r);
    logic [8*W-1:0] v;
    for (int c = 0; c < W; c++) v[8*c +: 8] = 8'(16 * r + c);
    return v;
  endfunction

  // Pixel array emulation: the selected row appears on the bus, or a constant pattern.
  always_comb begin
    pix_data = '0;
    if (pix_const) begin
      pix_data = {W{8'hA5}};
    end else begin
      for (int r = 0; r < H; r++) if (read[r]) pix_data = row_pattern(r);
    end
  end

  // Timeline model: m_o is the frame offset of the current cycle (1 = first erase cycle).
  bit             m_run = 1'b0;
  int             m_o = 0;
  logic [8*W-1:0] m_data = '0;
  logic [RW-1:0]  m_idx = '0;

  always @(posedge clk) begin : model
    int q, row, pos;
    q   = m_o - B - 1;
    row = (q >= 0) ? q / ROWLEN : -1;
    pos = (q >= 0) ? q % ROWLEN : 0;
    if (!reset) begin
      m_run  <= 1'b0;
      m_o    <= 0;
      m_data <= '0;
      m_idx  <= '0;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1'b1;
        m_o   <= 1;
      end
    end else if (row == H) begin
`ifdef PIXEL_CONTINUOUS_EN
      m_o <= 1;
`else
      m_run <= 1'b0;
      m_o   <= 0;
`endif
    end else if (row >= 0 && pos == CR) begin
      if (row_ready) m_o <= m_o + 1;
    end else begin
      if (row >= 0 && pos == CR - 1) begin
        m_data <= pix_const ? {W{8'hA5}} : row_pattern(row);
        m_idx  <= RW'(row);
      end
      m_o <= m_o + 1;
    end
  end

  logic         e_erase, e_expose, e_convert, e_valid, e_busy, e_done;
  logic [H-1:0] e_read;

  // Expected phase outputs from the model offset.
  always_comb begin
    int q, row, pos;
    e_erase   = 1'b0;
    e_expose  = 1'b0;
    e_convert = 1'b0;
    e_valid   = 1'b0;
    e_done    = 1'b0;
    e_read    = '0;
    e_busy    = m_run;
    q         = m_o - B - 1;
    row       = (q >= 0) ? q / ROWLEN : -1;
    pos       = (q >= 0) ? q % ROWLEN : 0;
    if (m_run) begin
      if (m_o >= 1 && m_o <= CE) e_erase = 1'b1;
      else if (m_o > CE && m_o <= CE + CX) e_expose = 1'b1;
      else if (m_o > CE + CX && m_o <= B) e_convert = 1'b1;
      else if (row >= 0 && row < H) begin
        if (pos < CR) begin
          for (int i = 0; i < H; i++) if (i == row) e_read[i] = 1'b1;
        end else begin
          e_valid = 1'b1;
        end
      end else if (row == H) e_done = 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("erase", 64'(erase), 64'(e_erase));
      check("expose", 64'(expose), 64'(e_expose));
      check("convert", 64'(convert), 64'(e_convert));
      check("read", 64'(read), 64'(e_read));
      check("row_valid", 64'(row_valid), 64'(e_valid));
      check("row_idx", 64'(row_idx), 64'(m_idx));
      check("row_data", 64'(row_data), 64'(m_data));
      check("busy", 64'(busy), 64'(e_busy));
      check("frame_done", 64'(frame_done), 64'(e_done));
    end
  end

  // Reset, start at cycle 0, then run ncyc cycles with per-scenario drive and literal pins.
  task automatic run_test(input int id, input int ncyc, output int dones);
    dones = 0;
    @(negedge clk);
    reset     = 1'b0;
    start     = 1'b0;
    row_ready = 1'b1;
    pix_const = (id == 32);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (frame_done === 1'b1) dones++;
      if (id == 31) begin
        case (n)
          1:  begin check("t31_erase1", 64'(erase), 64'd1); check("t31_busy1", 64'(busy), 64'd1); end
          5:  check("t31_erase5", 64'(erase), 64'd1);
          6:  begin check("t31_erase6", 64'(erase), 64'd0); check("t31_expose6", 64'(expose), 64'd1); end
          15: check("t31_expose15", 64'(expose), 64'd1);
          16: begin check("t31_convert16", 64'(convert), 64'd1); check("t31_expose16", 64'(expose), 64'd0); end
          23: check("t31_convert23", 64'(convert), 64'd1);
          24: begin check("t31_read24", 64'(read), 64'h1); check("t31_convert24", 64'(convert), 64'd0); end
          25: check("t31_read25", 64'(read), 64'h1);
          26: begin
            check("t31_read26", 64'(read), 64'h0);
            check("t31_valid26", 64'(row_valid), 64'd1);
            check("t31_idx26", 64'(row_idx), 64'd0);
          end
          27: check("t31_read27", 64'(read), 64'h2);
          28: check("t31_read28", 64'(read), 64'h2);
          32: check("t31_idx32", 64'(row_idx), 64'd2);
          35: check("t31_idx35", 64'(row_idx), 64'd3);
          36: check("t31_done36", 64'(frame_done), 64'd1);
          37: begin
            check("t31_done37", 64'(frame_done), 64'd0);
`ifdef PIXEL_CONTINUOUS_EN
            check("t31_busy37", 64'(busy), 64'd1);
`else
            check("t31_busy37", 64'(busy), 64'd0);
`endif
          end
          default: ;
        endcase
      end
      if (id == 35) begin
        case (n)
          26: check("t35_row0", 64'(row_data), 64'h03020100);
          29: check("t35_row1", 64'(row_data), 64'h13121110);
          32: check("t35_row2", 64'(row_data), 64'h23222120);
          35: check("t35_row3", 64'(row_data), 64'h33323130);
          default: ;
        endcase
      end
      if (id == 32) begin
        case (n)
          29: begin
            check("t32_idx29", 64'(row_idx), 64'd1);
            check("t32_data29", 64'(row_data), 64'hA5A5A5A5);
          end
          35: begin
            check("t32_read35", 64'(read), 64'h0);
            check("t32_valid35", 64'(row_valid), 64'd1);
            check("t32_data35", 64'(row_data), 64'hA5A5A5A5);
          end
          39: begin check("t32_read39", 64'(read), 64'h0); check("t32_valid39", 64'(row_valid), 64'd1); end
          40: begin check("t32_read40", 64'(read), 64'h4); check("t32_valid40", 64'(row_valid), 64'd0); end
          46: check("t32_done46", 64'(frame_done), 64'd1);
          default: ;
        endcase
      end
      if (id == 33) begin
        case (n)
          10: check("t33_expose10", 64'(expose), 64'd1);
          11: begin
            check("t33_all11", 64'({erase, expose, convert, read, row_valid, busy, frame_done}), 64'd0);
            check("t33_data11", 64'({row_data, row_idx}), 64'd0);
          end
          16: check("t33_erase16", 64'(erase), 64'd1);
          20: check("t33_erase20", 64'(erase), 64'd1);
          21: begin check("t33_erase21", 64'(erase), 64'd0); check("t33_expose21", 64'(expose), 64'd1); end
          default: ;
        endcase
      end
      if (id == 34 && n == 21) begin
        check("t34_erase21", 64'(erase), 64'd0);
        check("t34_convert21", 64'(convert), 64'd1);
      end
`ifdef PIXEL_CONTINUOUS_EN
      if (id == 36) begin
        case (n)
          36: check("t36_done36", 64'(frame_done), 64'd1);
          37: begin check("t36_erase37", 64'(erase), 64'd1); check("t36_busy37", 64'(busy), 64'd1); end
          72: check("t36_done72", 64'(frame_done), 64'd1);
          73: check("t36_erase73", 64'(erase), 64'd1);
          default: ;
        endcase
      end
`endif
      // Drive inputs for the edge that ends cycle n.
      case (id)
        32: row_ready = !(n >= 29 && n <= 38);
        33: begin reset = (n != 10); start = (n == 15); end
        34: start = (n == 3 || n == 20);
        5:  row_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
    reset     = 1'b1;
    start     = 1'b0;
    row_ready = 1'b1;
  endtask

  initial begin
    int dones;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    run_test(31, 45, dones);
    check("t31_frame_done_count", 64'(dones), 64'd1);
    run_test(35, 40, dones);
    check("t35_frame_done_count", 64'(dones), 64'd1);
    run_test(32, 50, dones);
    check("t32_frame_done_count", 64'(dones), 64'd1);
    run_test(33, 30, dones);
    check("t33_frame_done_count", 64'(dones), 64'd0);
    run_test(34, 45, dones);
    check("t34_frame_done_count", 64'(dones), 64'd1);
    run_test(5, 120, dones);
`ifdef PIXEL_CONTINUOUS_EN
    run_test(36, 80, dones);
    check("t36_frame_done_count", 64'(dones), 64'd2);
`endif
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_frame_scheduler.md
PIXEL_FRAME_SCHEDULER -- requirements
Module: pixel_frame_scheduler

Interface
REQ-001 SHALL have parameter H, default 4: pixel array rows.
REQ-002 SHALL have parameter W, default 4: pixel array columns.
REQ-003 SHALL have parameters C_ERASE=5, C_EXPOSE=255, C_CONVERT=255, C_READ=5: phase lengths in clk cycles, each 1..65535.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous reset, active-low.
REQ-006 SHALL have port start  input  1  frame request, sampled in IDLE only.
REQ-007 SHALL have port erase  output  1  pixel erase phase.
REQ-008 SHALL have port expose  output  1  pixel exposure phase; also the exposure-clock gate.
REQ-009 SHALL have port convert  output  1  ADC ramp / gray counter enable.
REQ-010 SHALL have port read  output  H  one-hot row read select, one bit per row.
REQ-011 SHALL have port pix_data  input  8*W  row data bus from the array, column c at bits [8c+:8].
REQ-012 SHALL have port row_data  output  8*W  captured row, registered.
REQ-013 SHALL have port row_idx  output  $clog2(H) (min 1)  row number of row_data.
REQ-014 SHALL have port row_valid / row_ready  output / input  1 each  valid-ready handshake for row_data.
REQ-015 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-017 SHALL implement states IDLE, ERASE, EXPOSE, CONVERT, READ, WAIT_ACK, DONE with a 16-bit phase counter.
REQ-018 SHALL move IDLE->ERASE on the edge where start=1; erase goes high the next cycle.
REQ-019 SHALL keep erase, expose and convert high for exactly C_ERASE, C_EXPOSE and C_CONVERT cycles. They SHALL run back-to-back, each mutually exclusive with the others.
REQ-020 SHALL move from CONVERT to READ with row counter 0, and drive read[r] high for exactly C_READ cycles; all other read bits stay 0.
REQ-021 SHALL, on the edge ending the last READ cycle: load row_data<=pix_data and row_idx<=r, set row_valid=1, drop read, and enter WAIT_ACK.
REQ-022 SHALL hold row_data, row_idx and row_valid stable while row_valid=1 and row_ready=0; read stays all-zero during the stall.
REQ-023 SHALL treat a transfer as row_valid&&row_ready at an edge. On transfer: row_valid<=0; if r<H-1, go to READ with r+1; else go to DONE.
REQ-024 SHALL allow row_ready to be high before row_valid; the transfer then occurs on the first WAIT_ACK edge, so latency from the last read cycle to the next read[r+1] is 2 cycles.
REQ-025 SHALL assert frame_done for the single DONE cycle, then return to IDLE.
REQ-026 SHALL ignore start outside IDLE; start held high in IDLE begins a new frame on the next IDLE cycle.
REQ-027 SHALL handle H=1 by going WAIT_ACK->DONE after row 0.

Reset
REQ-028 SHALL, on a clock edge with reset=0 (any state, including mid-frame), enter IDLE and clear the phase and row counters. It SHALL set erase, expose, convert, read, row_valid, busy, frame_done, row_data and row_idx to 0.
REQ-029 SHALL NOT produce a row transfer on the edge where reset is low, even if row_ready=1.

Configuration
REQ-030 SHALL provide macro PIXEL_CONTINUOUS_EN. When defined, DONE goes to ERASE instead of IDLE and busy stays high; a frame still needs start from IDLE only after reset. When undefined, DONE goes to IDLE and one frame runs per start.

Verification (H=4, W=4, C_ERASE=5, C_EXPOSE=10, C_CONVERT=8, C_READ=2, cycle 0 = start edge)
REQ-031 SHALL test a single start pulse with row_ready=1. Expected: erase on cycles 1-5, expose 6-15, convert 16-23, read[0] 24-25, row_valid on 26, read[1] 27-28, and the full frame with row_idx 0..3. frame_done pulses once, then busy=0.
REQ-032 SHALL test back-pressure. Hold row_ready=0 for 10 cycles while row_idx=1 with pix_data=32'hA5A5A5A5. Expected: row_data stays A5A5A5A5, read=0, and no read[2] until the cycle after the ready transfer.
REQ-033 SHALL test reset=0 at cycle 10 (mid-expose). Expected: all outputs 0 on the next cycle, state IDLE; a later start restarts erase for 5 cycles.
REQ-034 SHALL test start pulses at cycles 3 and 20. Expected: both ignored, only one frame_done.
REQ-035 SHALL test a distinct pix_data per row (8'h10*r+c). Expected: row_data for row r matches at the handshake.
REQ-036 SHALL test with PIXEL_CONTINUOUS_EN defined. Expected: erase re-asserts the cycle after frame_done; two consecutive frames complete without start.
